// File: rtl/servio_ram_dma.sv
// Byte mover between the dual-port servio RAM and a pair of valid/ready streams.
// Reads go RAM to m_*; writes go s_* to RAM; one command at a time.
module servio_ram_dma #(
    parameter  int DATA_DEPTH = 1024,
    parameter  int DATA_WIDTH = 8,
    localparam int AW         = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [AW-1:0]         cmd_addr,
    input  logic [AW:0]           cmd_len,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         wb_m0_adr,
    output logic                  wb_m0_cyc,
    input  logic [DATA_WIDTH-1:0] wb_m0_rdt,
    input  logic                  wb_m0_ack,
    output logic [AW-1:0]         wb_m1_adr,
    output logic                  wb_m1_cyc,
    output logic                  wb_m1_we,
    output logic [DATA_WIDTH-1:0] wb_m1_dat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_HOLD,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [AW:0]   REM_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_MAX = AW'(DATA_DEPTH - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [AW-1:0]           r_ptr;
    logic [AW:0]             r_rem;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic                    r_m_last;
    logic [AW-1:0]           r_m1_adr;
    logic [DATA_WIDTH-1:0]   r_m1_dat;
    logic                    r_m1_cyc;
    logic [AW-1:0]           w_ptr_inc;
    logic                    w_rem_one;

    // Explicit compare keeps the wrap correct for non-power-of-2 depths
    assign w_ptr_inc = (r_ptr == PTR_MAX) ? '0 : r_ptr + AW'(1);
    assign w_rem_one = (r_rem == REM_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0)
                        w_next = S_DONE;
                    else if (cmd_dir)
                        w_next = S_WR;
                    else
                        w_next = S_RD_REQ;
                end
            end
            S_RD_REQ:  w_next = S_RD_WAIT;
            S_RD_WAIT: if (wb_m0_ack) w_next = S_RD_HOLD;
            S_RD_HOLD: begin
                if (m_ready)
                    w_next = w_rem_one ? S_DONE : S_RD_REQ;
            end
            S_WR:      if (s_valid && w_rem_one) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        s_ready   = (r_state == S_WR);
        m_valid   = (r_state == S_RD_HOLD);
        m_last    = (r_state == S_RD_HOLD) && r_m_last;
        wb_m0_cyc = (r_state == S_RD_REQ);
        wb_m0_adr = r_ptr;
        m_data    = r_m_data;
        wb_m1_adr = r_m1_adr;
        wb_m1_dat = r_m1_dat;
        wb_m1_cyc = r_m1_cyc;
        wb_m1_we  = r_m1_cyc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_rem    <= '0;
            r_m_data <= '0;
            r_m_last <= 1'b0;
            r_m1_adr <= '0;
            r_m1_dat <= '0;
            r_m1_cyc <= 1'b0;
        end else begin
            // Strobe lasts exactly the cycle after each inbound handshake
            r_m1_cyc <= (r_state == S_WR) && s_valid;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_ptr <= cmd_addr;
                        r_rem <= cmd_len;
                    end
                end
                S_RD_WAIT: begin
                    if (wb_m0_ack) begin
                        r_m_data <= wb_m0_rdt;
                        r_m_last <= w_rem_one;
                    end
                end
                S_RD_HOLD: begin
                    if (m_ready) begin
                        r_ptr <= w_ptr_inc;
                        r_rem <= r_rem - REM_ONE;
                    end
                end
                S_WR: begin
                    if (s_valid) begin
                        r_m1_adr <= r_ptr;
                        r_m1_dat <= s_data;
                        r_ptr    <= w_ptr_inc;
                        r_rem    <= r_rem - REM_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
